// File: rtl/sh4a_fetch_queue.sv
// SH-4A instruction fetch queue: credit-limited word fetch from imem, halfword
// issue to decode with PC, and redirect flush that discards stale responses.
module sh4a_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hA000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        insn_valid,
  output logic [15:0] insn,
  output logic [31:0] insn_pc,
  input  logic        insn_ready
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   slot_data [DEPTH];
  logic [29:0]   slot_addr [DEPTH];
  logic          slot_skip [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   fetch_pc;
  logic [29:0]   push_addr;
  logic          head_half, skip_first, run;

  logic          req_fire, push, pop, consume, eff_half;
  logic [CW:0]   credit_used;
  logic          unused_pc_bit;

  assign unused_pc_bit = redirect_pc[0];

  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = run && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A word pushed with the skip flag starts at its upper half, so the
  // effective half is the OR of the head pointer and the slot's flag.
  assign eff_half   = head_half | slot_skip[rd_ptr];
  assign insn_valid = (count != '0);
  assign insn       = insn_valid ? (eff_half ? slot_data[rd_ptr][31:16]
                                             : slot_data[rd_ptr][15:0]) : '0;
  assign insn_pc    = insn_valid ? {slot_addr[rd_ptr], eff_half, 1'b0} : '0;

  assign consume = insn_valid && insn_ready && !redirect_valid;
  assign pop     = consume && eff_half;
  assign push    = imem_resp_valid && (discard == '0) && !redirect_valid;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  always_ff @(posedge clk) begin
    if (push) begin
      slot_data[wr_ptr] <= imem_resp_data;
      slot_addr[wr_ptr] <= push_addr;
      slot_skip[wr_ptr] <= skip_first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      push_addr   <= RESET_PC[31:2];
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head_half   <= 1'b0;
      skip_first  <= 1'b0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        head_half  <= 1'b0;
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        push_addr  <= redirect_pc[31:2];
        skip_first <= redirect_pc[1];
        // Everything still in flight after this edge is stale, including a
        // request firing now; a response arriving now is already dropped.
        discard    <= outstanding_nxt;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (imem_resp_valid && (discard != '0))
          discard <= discard - 1'b1;
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          push_addr  <= push_addr + 30'd1;
          skip_first <= 1'b0;
        end
        if (consume)
          head_half <= !eff_half;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_sh4a_fetch_queue.sv
// Self-checking bench for sh4a_fetch_queue: memory responder plus an
// instruction-level reference model (queue of halfwords, tagged requests).
module tb_sh4a_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        insn_valid;
  logic [15:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready = 1'b0;

  always #5 clk = ~clk;

  sh4a_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc),
    .insn_ready(insn_ready)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] daddr; logic [31:0] due; logic stale; } req_t;
  typedef struct packed { logic [15:0] h; logic [31:0] pc; } ins_t;

  req_t        memq[$];
  ins_t        iq[$];
  ins_t        consumed[$];
  logic [31:0] fired[$];
  logic [31:0] m_fetch_pc;
  bit          m_run, m_skip, jitter;
  int unsigned cyc, lat;
  // {insn_valid, insn, insn_pc, imem_req_valid, imem_req_addr}
  logic [81:0] obs_v, exp_v;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hA000_0000) return 32'h2233_0009;
    if (a == 32'hA000_0004) return 32'h0117_000B;
    return {a[17:2] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  function automatic int model_words();
    int n = 0;
    foreach (iq[i]) if (iq[i].pc[1]) n++;
    return n;
  endfunction

  task automatic model_reset();
    iq.delete();
    memq.delete();
    m_fetch_pc = RESET_PC;
    m_run = 1'b0;
    m_skip = 1'b0;
  endtask

  // One clock cycle: drive inputs, capture expected and observed outputs, advance model.
  task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [31:0] rpc);
    bit resp, fire, cons, exp_rv;
    req_t r;
    logic [31:0] w;
    resp = rst_n && memq.size() > 0 && memq[0].due <= cyc && (!jitter || $urandom_range(0, 3) != 0);
    w = resp ? mem_word(memq[0].daddr) : $urandom();
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = rq_rdy;
    insn_ready      = in_rdy;
    imem_resp_valid = resp;
    imem_resp_data  = w;
    exp_rv = m_run && (model_words() + memq.size() < DEPTH);
    exp_v  = {1'b0, 16'h0, 32'h0, exp_rv, m_fetch_pc};
    if (iq.size() > 0) exp_v[81:33] = {1'b1, iq[0].h, iq[0].pc};
    #1;
    obs_v = {insn_valid, insn, insn_pc, imem_req_valid, imem_req_addr};
    if (imem_req_valid && rq_rdy) fired.push_back(imem_req_addr);
    if (insn_valid && in_rdy && !redir) consumed.push_back({insn, insn_pc});
    fire = exp_rv && rq_rdy;
    cons = iq.size() > 0 && in_rdy;
    if (!rst_n) model_reset();
    else begin
      if (resp) r = memq.pop_front();
      if (fire) begin
        memq.push_back({m_fetch_pc, imem_req_addr, cyc + lat, 1'b0});
        m_fetch_pc += 32'd4;
      end
      if (redir) begin
        iq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        m_fetch_pc = {rpc[31:2], 2'b00};
        m_skip = rpc[1];
      end else begin
        if (cons) void'(iq.pop_front());
        if (resp && !r.stale) begin
          if (!m_skip) iq.push_back({w[15:0], r.addr[31:2], 2'b00});
          iq.push_back({w[31:16], r.addr[31:2], 2'b10});
          m_skip = 1'b0;
        end
      end
      m_run = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    lat = 1; jitter = 0;
    @(posedge clk); #1;
    repeat (3) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      checks++;
      if (obs_v !== {1'b0, 16'h0, 32'h0, 1'b0, RESET_PC}) begin
        failures++; $display("FAIL reset_outputs got=%h exp=%h", obs_v, {1'b0, 16'h0, 32'h0, 1'b0, RESET_PC});
      end
    end
  endtask

  task automatic test_reset_fetch();
    logic [15:0] eh [4];
    logic [31:0] ep [4];
    eh = '{16'h0009, 16'h2233, 16'h000B, 16'h0117};
    ep = '{32'hA000_0000, 32'hA000_0002, 32'hA000_0004, 32'hA000_0006};
    rst_n = 1'b1;
    consumed.delete(); fired.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_fetch cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (k < 2) begin
        checks++;
        if (obs_v[32] !== (k == 1)) begin failures++; $display("FAIL first_req_valid k=%0d got=%b exp=%b", k, obs_v[32], k == 1); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (consumed.size() <= i || consumed[i].h !== eh[i] || consumed[i].pc !== ep[i]) begin
        failures++;
        $display("FAIL reset_fetch_insn i=%0d got=%h exp=%h@%h", i, (consumed.size() > i) ? consumed[i] : '0, eh[i], ep[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc, w;
    logic [15:0] h;
    lat = 1; jitter = 0;
    step(1'b1, 1'b1, 1'b1, 32'h8000_0000);
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL bp_redirect got=%h exp=%h", obs_v, exp_v); end
    fired.delete(); consumed.delete();
    repeat (12) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (fired.size() != DEPTH) begin failures++; $display("FAIL bp_fetch_count got=%0d exp=%0d", fired.size(), DEPTH); end
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", imem_req_valid); end
    repeat (2 * DEPTH + 6) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      pc = 32'h8000_0000 + 32'(2 * i);
      w  = mem_word({pc[31:2], 2'b00});
      h  = pc[1] ? w[31:16] : w[15:0];
      checks++;
      if (consumed.size() <= i || consumed[i].pc !== pc || consumed[i].h !== h) begin
        failures++;
        $display("FAIL bp_order i=%0d got=%h exp=%h@%h", i, (consumed.size() > i) ? consumed[i] : '0, h, pc);
      end
    end
  endtask

  task automatic test_odd_redirect();
    logic [31:0] w;
    lat = 3; jitter = 0;
    step(1'b0, 1'b1, 1'b1, 32'h9000_0000);
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL odd_pre got=%h exp=%h", obs_v, exp_v); end
    for (int k = 0; k < 20 && memq.size() > 0; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL odd_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (memq.size() != 0) begin failures++; $display("FAIL odd_drain_timeout got=%0d exp=0", memq.size()); end
    repeat (2) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL odd_fire cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    step(1'b0, 1'b1, 1'b1, 32'h8C00_0102);
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL odd_redirect got=%h exp=%h", obs_v, exp_v); end
    consumed.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_v[81] !== 1'b0) begin failures++; $display("FAIL odd_valid_after_redirect got=%b exp=0", obs_v[81]); end
    for (int k = 0; k < 30 && consumed.size() < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL odd_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    w = mem_word(32'h8C00_0100);
    checks++;
    if (consumed.size() < 1 || consumed[0].pc !== 32'h8C00_0102 || consumed[0].h !== w[31:16]) begin
      failures++; $display("FAIL odd_first_insn got=%h exp=%h@8c000102", (consumed.size() > 0) ? consumed[0] : '0, w[31:16]);
    end
    checks++;
    if (consumed.size() < 2 || consumed[1].pc !== 32'h8C00_0104) begin
      failures++; $display("FAIL odd_second_pc got=%h exp=8c000104", (consumed.size() > 1) ? consumed[1].pc : '0);
    end
  endtask

  task automatic test_redirect_collision();
    bit hit, found;
    lat = 1; jitter = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      hit = memq.size() > 0 && memq[0].due <= cyc && iq.size() > 0 && m_run &&
            (model_words() + memq.size() < DEPTH);
      step(1'b1, 1'b1, hit, 32'hA100_0000);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL coll_setup cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      found = hit;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL coll_not_reached got=0 exp=1"); end
    consumed.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_v[81] !== 1'b0) begin failures++; $display("FAIL coll_valid_after got=%b exp=0", obs_v[81]); end
    repeat (20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL coll_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (consumed.size() < 1 || consumed[0].pc !== 32'hA100_0000) begin
      failures++; $display("FAIL coll_first_pc got=%h exp=a1000000", (consumed.size() > 0) ? consumed[0].pc : '0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [3];
    logic [31:0] ip [4];
    ea = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    ip = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
    lat = 2; jitter = 0;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL wrap_redirect got=%h exp=%h", obs_v, exp_v); end
    fired.delete(); consumed.delete();
    repeat (12) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL wrap_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fired.size() <= i || fired[i] !== ea[i]) begin
        failures++; $display("FAIL wrap_req_addr i=%0d got=%h exp=%h", i, (fired.size() > i) ? fired[i] : '0, ea[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (consumed.size() <= i || consumed[i].pc !== ip[i]) begin
        failures++; $display("FAIL wrap_insn_pc i=%0d got=%h exp=%h", i, (consumed.size() > i) ? consumed[i].pc : '0, ip[i]);
      end
    end
  endtask

  task automatic test_throughput();
    int nvalid;
    lat = 2; jitter = 0;
    step(1'b1, 1'b1, 1'b1, 32'hB000_0000);
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL tp_redirect got=%h exp=%h", obs_v, exp_v); end
    nvalid = 0;
    for (int k = 0; k < 36; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL tp_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (k >= 20 && obs_v[81] === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 16) begin failures++; $display("FAIL tp_no_bubbles got=%0d exp=16", nvalid); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    jitter = 1;
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) lat = $urandom_range(1, 4);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, rpc);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    jitter = 0;
  endtask

  task automatic test_async_reset();
    lat = 1; jitter = 0;
    repeat (6) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL ar_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs_v = {insn_valid, insn, insn_pc, imem_req_valid, imem_req_addr};
    checks++;
    if (obs_v !== {1'b0, 16'h0, 32'h0, 1'b0, RESET_PC}) begin
      failures++; $display("FAIL ar_immediate got=%h exp=%h", obs_v, {1'b0, 16'h0, 32'h0, 1'b0, RESET_PC});
    end
    model_reset();
    @(posedge clk); #1;
    cyc++;
    repeat (2) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL ar_held cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    rst_n = 1'b1;
    fired.delete(); consumed.delete();
    repeat (8) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL ar_restart cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (fired.size() < 1 || fired[0] !== 32'hA000_0000) begin
      failures++; $display("FAIL ar_first_req got=%h exp=a0000000", (fired.size() > 0) ? fired[0] : '0);
    end
    checks++;
    if (consumed.size() < 1 || consumed[0].pc !== 32'hA000_0000 || consumed[0].h !== 16'h0009) begin
      failures++; $display("FAIL ar_first_insn got=%h exp=0009@a0000000", (consumed.size() > 0) ? consumed[0] : '0);
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_odd_redirect();
    test_redirect_collision();
    test_wrap();
    test_throughput();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
